// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered UART transmitter behind a request/ready bus.
// The CPU pushes bytes into a circular FIFO. A serializer drains the FIFO as
// 8N1 frames, one bit per 8*PRESCALE clocks, with no idle gap between queued
// frames. The block also provides a status register and a level TX-done
// interrupt.
module uart_tx_buffered #(
   parameter int PRESCALE      = 50000000 / (9600 * 8),
   parameter int TX_FIFO_DEPTH = 64
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_request,
   input  logic        i_rw,
   input  logic [1:0]  i_address,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_ready,
   output logic        o_interrupt,
   output logic        UART_TX
);

   localparam int AW = $clog2(TX_FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   // ---------------------------------------------------------------- bus side
   logic        access;
   logic        push_req;
   logic        stall;
   logic        ie;
   logic [31:0] status;

   // ------------------------------------------------------------------- FIFO
   logic [7:0]    mem [TX_FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          empty;
   logic          full;
   logic          push;
   logic          pop;

   // ------------------------------------------------------------- serializer
   state_t        state;
   state_t        state_next;
   logic [PW-1:0] presc_cnt;
   logic [2:0]    os_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          bit_done;
   logic          busy;
   logic          tx_bit;

   // Only the low byte and bit 0 of the write data carry meaning.
   logic unused_wdata;
   assign unused_wdata = ^i_wdata[31:8];

   // A new access starts only when ready is low. A request still held in the
   // ready cycle is the tail of the previous access.
   assign access   = i_request && !o_ready;
   assign push_req = access && i_rw && (i_address == 2'd0);
   // A simultaneous pop frees the slot in the same edge, so a write into a
   // full FIFO still succeeds when the serializer pops in that edge.
   assign push     = push_req && (!full || pop);
   assign stall    = push_req && !push;

   assign empty  = (count == '0);
   assign full   = (count == CW'(TX_FIFO_DEPTH));
   assign busy   = (state != S_IDLE);
   assign status = {16'(count), 12'b0, ie, busy, full, empty};

   assign bit_done = (presc_cnt == PW'(PRESCALE - 1)) && (os_cnt == 3'd7);

   // Bus register file: ready pulse, registered read data, interrupt enable.
   // NOTE: sequential state uses non-blocking assignments so that every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         o_ready <= 1'b0;
         o_rdata <= '0;
         ie      <= 1'b0;
      end else begin
         o_ready <= access && !stall;
         o_rdata <= (access && !i_rw && (i_address == 2'd1)) ? status : '0;
         if (access && i_rw && (i_address == 2'd1)) begin
            ie <= i_wdata[0];
         end
      end
   end

   // FIFO storage: written on push only.
   // NOTE: the data array has no reset. Pointers and count define which
   // entries are valid, so clearing the array would add logic with no effect.
   always_ff @(posedge i_clock) begin
      if (push) begin
         mem[wr_ptr] <= i_wdata[7:0];
      end
   end

   // FIFO pointers and occupancy. The pointers wrap modulo the depth.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Serializer state register.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Serializer next-state logic. After the stop bit, go straight to the next
   // start bit when more data is queued.
   // NOTE: every combinational output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (!empty)                       state_next = S_START;
         S_START: if (bit_done)                     state_next = S_DATA;
         S_DATA:  if (bit_done && bit_idx == 3'd7)  state_next = S_STOP;
         S_STOP:  if (bit_done)                     state_next = empty ? S_IDLE : S_START;
         default:                                   state_next = S_IDLE;
      endcase
   end

   // Serializer outputs: FIFO pop strobe and the line level for this state.
   always_comb begin
      pop    = 1'b0;
      tx_bit = 1'b1;
      case (state)
         S_IDLE:  pop    = !empty;
         S_START: tx_bit = 1'b0;
         S_DATA:  tx_bit = shift[0];
         S_STOP:  pop    = bit_done && !empty;
         default: tx_bit = 1'b1;
      endcase
   end

   // Bit timing counters, shift register and the registered serial line.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         presc_cnt <= '0;
         os_cnt    <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         UART_TX   <= 1'b1;
      end else begin
         UART_TX <= tx_bit;
         if (pop) begin
            shift <= mem[rd_ptr];
         end else if (state == S_DATA && bit_done) begin
            shift <= {1'b0, shift[7:1]};
         end
         if (state == S_IDLE) begin
            presc_cnt <= '0;
            os_cnt    <= '0;
            bit_idx   <= '0;
         end else begin
            if (presc_cnt == PW'(PRESCALE - 1)) begin
               presc_cnt <= '0;
               os_cnt    <= os_cnt + 1'b1;
            end else begin
               presc_cnt <= presc_cnt + 1'b1;
            end
            if (state == S_DATA && bit_done) begin
               bit_idx <= bit_idx + 1'b1;
            end
         end
      end
   end

   // TX-done interrupt, registered: enabled, nothing queued, line idle.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         o_interrupt <= 1'b0;
      end else begin
         o_interrupt <= ie && empty && !busy;
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with PRESCALE=2 (16-clock bits,
// 160-clock frames) and a 4-entry FIFO. Inputs change 1 time unit after a
// rising edge. Outputs are sampled at that same point.
module tb_uart_tx_buffered;

   localparam int PRESCALE   = 2;
   localparam int DEPTH      = 4;
   localparam int BIT_CLKS   = 8 * PRESCALE;
   localparam int FRAME_CLKS = 10 * BIT_CLKS;

   logic        i_clock   = 1'b0;
   logic        i_reset   = 1'b0;
   logic        i_request = 1'b0;
   logic        i_rw      = 1'b0;
   logic [1:0]  i_address = '0;
   logic [31:0] i_wdata   = '0;
   logic [31:0] o_rdata;
   logic        o_ready;
   logic        o_interrupt;
   logic        UART_TX;

   int n_checks = 0;
   int n_pass   = 0;

   uart_tx_buffered #(
      .PRESCALE      (PRESCALE),
      .TX_FIFO_DEPTH (DEPTH)
   ) dut (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_request   (i_request),
      .i_rw        (i_rw),
      .i_address   (i_address),
      .i_wdata     (i_wdata),
      .o_rdata     (o_rdata),
      .o_ready     (o_ready),
      .o_interrupt (o_interrupt),
      .UART_TX     (UART_TX)
   );

   always #5 i_clock = ~i_clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   // One bus access. Returns the read data and the number of cycles until
   // ready appears. Leaves one idle cycle afterwards and checks that ready
   // stayed high for only one cycle.
   task automatic bus(input logic rw, input logic [1:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output int cycles);
      i_request = 1'b1;
      i_rw      = rw;
      i_address = addr;
      i_wdata   = wd;
      cycles    = 0;
      do begin
         @(posedge i_clock); #1;
         cycles++;
      end while (o_ready !== 1'b1 && cycles < 2000);
      if (o_ready !== 1'b1) check("bus_timeout", 32'd0, 32'd1);
      rd        = o_rdata;
      i_request = 1'b0;
      i_rw      = 1'b0;
      i_wdata   = '0;
      @(posedge i_clock); #1;
      check("ready_pulse", {31'd0, o_ready}, 32'd0);
   endtask

   task automatic wr(input logic [1:0] addr, input logic [31:0] wd);
      logic [31:0] rd;
      int cyc;
      bus(1'b1, addr, wd, rd, cyc);
   endtask

   // Waits for a start bit, then compares the line on every clock against
   // n back-to-back frames followed by 4 idle-high clocks. Also records the
   // sample index where the interrupt first reads high (-1 if it never does).
   task automatic watch(input int n, input logic [47:0] bytes,
                        output int wait_cycles, output int errs, output int irq_rise);
      logic [7:0] b;
      logic       exp;
      int         bi;
      wait_cycles = 0;
      errs        = 0;
      irq_rise    = -1;
      while (UART_TX !== 1'b0 && wait_cycles < 400) begin
         @(posedge i_clock); #1;
         wait_cycles++;
      end
      if (UART_TX !== 1'b0) begin
         check("start_timeout", 32'd0, 32'd1);
         errs = -1;
         return;
      end
      for (int i = 0; i < n * FRAME_CLKS + 4; i++) begin
         if (i > 0) begin
            @(posedge i_clock); #1;
         end
         bi = (i % FRAME_CLKS) / BIT_CLKS;
         if (i >= n * FRAME_CLKS) exp = 1'b1;
         else if (bi == 0)        exp = 1'b0;
         else if (bi == 9)        exp = 1'b1;
         else begin
            b   = bytes[8 * (i / FRAME_CLKS) +: 8];
            exp = b[bi - 1];
         end
         if (UART_TX !== exp) errs++;
         if (irq_rise < 0 && o_interrupt === 1'b1) irq_rise = i;
      end
   endtask

   logic [31:0] rd;
   int          cyc;
   int          w, e, r;
   int          zeros;

   initial begin
      // Asynchronous reset, asserted between clock edges.
      #2 i_reset = 1'b1;
      #1;
      check("rst_tx",    {31'd0, UART_TX},     32'd1);
      check("rst_ready", {31'd0, o_ready},     32'd0);
      check("rst_irq",   {31'd0, o_interrupt}, 32'd0);
      repeat (3) @(posedge i_clock);
      #3 i_reset = 1'b0;
      @(posedge i_clock); #1;
      bus(1'b0, 2'd1, '0, rd, cyc);
      check("rst_status", rd, 32'h0000_0001);

      // Register map corners.
      bus(1'b0, 2'd0, '0, rd, cyc);
      check("rd_addr0", rd, 32'd0);
      wr(2'd2, 32'hFFFF_FFFF);
      bus(1'b0, 2'd3, '0, rd, cyc);
      check("rd_addr3", rd, 32'd0);
      bus(1'b0, 2'd1, '0, rd, cyc);
      check("status_after_addr2_wr", rd, 32'h0000_0001);

      // Single byte 0xA5.
      bus(1'b1, 2'd0, 32'h0000_00A5, rd, cyc);
      check("wr_latency", cyc, 32'd1);
      watch(1, 48'h0000_0000_00A5, w, e, r);
      check("a5_start_lat", w, 32'd1);
      check("a5_frame_errs", e, 32'd0);
      check("a5_no_irq", r, -32'sd1);

      // Burst of three bytes: contiguous frames, count 2 after first pop.
      fork
         begin
            wr(2'd0, 32'h11);
            wr(2'd0, 32'h22);
            wr(2'd0, 32'h33);
            bus(1'b0, 2'd1, '0, rd, cyc);
            check("burst_status", rd, 32'h0002_0004);
         end
         begin
            watch(3, 48'h0000_0033_2211, w, e, r);
            check("burst_start_lat", w, 32'd3);
            check("burst_frame_errs", e, 32'd0);
         end
      join

      // Full FIFO: the 6th write stalls until the first stop bit finishes.
      fork
         begin
            wr(2'd0, 32'h01);
            wr(2'd0, 32'h80);
            wr(2'd0, 32'hFF);
            wr(2'd0, 32'h00);
            wr(2'd0, 32'h3C);
            bus(1'b0, 2'd1, '0, rd, cyc);
            check("full_status", rd, 32'h0004_0006);
            bus(1'b1, 2'd0, 32'hC3, rd, cyc);
            check("stall_cycles", cyc, 32'd150);
         end
         begin
            watch(6, 48'hC33C_00FF_8001, w, e, r);
            check("stall_frame_errs", e, 32'd0);
         end
      join
      bus(1'b0, 2'd1, '0, rd, cyc);
      check("drained_status", rd, 32'h0000_0001);

      // Interrupt: set on enable while idle, cleared by a data write,
      // rises one clock after the stop state ends, cleared by IE=0.
      wr(2'd1, 32'h1);
      check("irq_ie_on", {31'd0, o_interrupt}, 32'd1);
      wr(2'd0, 32'h5A);
      check("irq_clr_data", {31'd0, o_interrupt}, 32'd0);
      watch(1, 48'h0000_0000_005A, w, e, r);
      check("5a_frame_errs", e, 32'd0);
      check("irq_rise_idx", r, 32'd160);
      wr(2'd1, 32'h0);
      check("irq_clr_ie", {31'd0, o_interrupt}, 32'd0);

      // Reset during data bit 3 of 0xF0 (a 0 bit) with two bytes queued.
      wr(2'd0, 32'hF0);
      wr(2'd0, 32'h12);
      wr(2'd0, 32'h34);
      repeat (69) @(posedge i_clock);
      #1;
      check("pre_reset_bit3", {31'd0, UART_TX}, 32'd0);
      #3 i_reset = 1'b1;
      #1;
      check("midrst_tx",    {31'd0, UART_TX},     32'd1);
      check("midrst_ready", {31'd0, o_ready},     32'd0);
      check("midrst_irq",   {31'd0, o_interrupt}, 32'd0);
      repeat (3) @(posedge i_clock);
      #3 i_reset = 1'b0;
      @(posedge i_clock); #1;
      bus(1'b0, 2'd1, '0, rd, cyc);
      check("midrst_status", rd, 32'h0000_0001);
      zeros = 0;
      repeat (400) begin
         @(posedge i_clock); #1;
         if (UART_TX !== 1'b1) zeros++;
      end
      check("no_frames_after_reset", zeros, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- FIFO-buffered UART transmitter; sits between the peripheral bus and the UART_TX pin.
- Replaces the unbuffered transmit path, so the CPU can post bursts of bytes without polling per byte.
- Uses the same request/ready bus handshake and oversampled PRESCALE convention as the receive side.
- Adds status readback and a TX-done interrupt.

Parameters:
- PRESCALE, 50000000 / (9600 * 8), clocks per oversample tick; one bit period = 8 * PRESCALE clocks.
- TX_FIFO_DEPTH, 64, transmit FIFO entries; power of two, >= 2.

Ports:
- i_clock  input  1  system clock.
- i_reset  input  1  asynchronous, active-high reset.
- i_request  input  1  bus access request; held by master until o_ready.
- i_rw  input  1  1 = write, 0 = read.
- i_address  input  2  register select.
- i_wdata  input  32  write data.
- o_rdata  output  32  read data; valid while o_ready is high on a read.
- o_ready  output  1  one-cycle access-complete pulse.
- o_interrupt  output  1  level interrupt: TX done.
- UART_TX  output  1  serial line, idle high.

Behaviour:
- Reset (asynchronous, active-high; applies immediately, including mid-frame and mid-access):
  - UART_TX=1, o_ready=0, o_rdata=0, o_interrupt=0.
  - FIFO emptied; IE=0; serializer to IDLE; prescale/bit counters cleared.
- Register map:
  - addr 0 write: push i_wdata[7:0].
  - addr 0 read: returns 0.
  - addr 1 write: IE = i_wdata[0].
  - addr 1 read: {16'(count), 12'b0, IE, busy, full, empty} at bits [31:16], [15:4], 3, 2, 1, 0.
  - addr 2/3: reads return 0; writes ignored; both complete normally.
- Handshake:
  - Access sampled on a rising edge with i_request=1 and o_ready=0; o_ready pulses high for exactly 1 cycle on the following cycle.
  - Master drops i_request in the o_ready cycle; a request still high in that cycle is not a new access.
  - Read data is registered and valid in the o_ready cycle.
- Full FIFO:
  - A write to addr 0 stalls (o_ready stays 0) until an entry frees.
  - Push occurs on the edge where space exists; o_ready pulses the next cycle.
  - No data is dropped, and no overflow occurs.
- FIFO:
  - Circular buffer with log2(DEPTH)-bit pointers that wrap modulo DEPTH; count is 0..DEPTH.
  - Simultaneous push and pop: count unchanged; both succeed even when full.
  - empty = (count==0); full = (count==DEPTH).
- Serializer FSM (IDLE, START, DATA, STOP):
  - IDLE: if FIFO non-empty, pop the head into the shift register; go to START; busy=1.
  - START: UART_TX=0 for 8*PRESCALE clocks.
  - DATA: 8 bits, LSB first, each 8*PRESCALE clocks; 3-bit index.
  - STOP: UART_TX=1 for 8*PRESCALE clocks. Then, if FIFO non-empty, pop and go directly to START (back-to-back frames, no idle gap); else go to IDLE, busy=0.
  - Frame length = 80*PRESCALE clocks.
  - UART_TX is registered; the first start-bit low appears 1 cycle after the pop edge.
- Interrupt: o_interrupt = IE & empty & !busy, registered (1-cycle lag).

Test Plan:
- Reset: assert i_reset for 3 cycles, asynchronously mid-cycle → UART_TX=1, o_ready=0, o_interrupt=0 immediately; status read returns 0x00000001.
- Single byte, PRESCALE=2: write 0xA5 to addr 0 → o_ready pulses 1 cycle after the request. Line shows 0 (16 clk), then 1,0,1,0,0,1,0,1 (16 clk each), then 1 (16 clk); total 160 clocks.
- Burst: write 0x11, 0x22, 0x33 back-to-back → three frames with no idle gap between stop and next start; status count reads 2 right after the first pop.
- Full stall, TX_FIFO_DEPTH=4: write 6 bytes quickly → the 6th write holds o_ready low until the first stop bit completes. All 6 bytes appear on the line in order, none lost.
- Interrupt: write 1 to addr 1, send 0x5A → o_interrupt=0 while busy; rises 1 cycle after STOP ends; clears on the next data write or on IE=0.
- Reset mid-frame: assert i_reset during data bit 3 with 2 bytes queued → UART_TX=1 immediately; after release, status=0x00000001 and no further frames.
